// File: rtl/ft245_tx_arbiter.sv
// ft245_tx_arbiter: packet-granular round-robin mux of two 16-bit sources onto the FT245 TX stream.
// Latency: 1 grant cycle + 1 header cycle, then payload passes combinationally from the granted source.
// Backpressure: m_rdy reaches only the granted source; the header is held until m_rdy; rst blocks all handshakes.
module ft245_tx_arbiter #(
    parameter logic [7:0]  HDR_MAGIC = 8'hA5,
    parameter int unsigned MAX_BURST = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_val,
    output logic        s0_rdy,
    input  logic [15:0] s0_data,
    input  logic        s0_last,
    input  logic        s1_val,
    output logic        s1_rdy,
    input  logic [15:0] s1_data,
    input  logic        s1_last,
    output logic        m_val,
    input  logic        m_rdy,
    output logic [15:0] m_data,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [11:0] LP_CNT_LAST = 12'(MAX_BURST - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_src;
    logic        w_src_nxt;
    logic        r_rr;
    logic        w_rr_nxt;
    logic [11:0] r_cnt;
    logic [11:0] w_cnt_nxt;
    logic [1:0]  r_grant;
    logic        r_busy;

    logic        w_g_val;
    logic        w_g_last;
    logic [15:0] w_g_data;
    logic        w_beat;
    logic        w_m_val;
    logic [15:0] w_m_data;
    logic        w_s0_rdy;
    logic        w_s1_rdy;

    assign w_g_val  = r_src ? s1_val  : s0_val;
    assign w_g_last = r_src ? s1_last : s0_last;
    assign w_g_data = r_src ? s1_data : s0_data;
    assign w_beat   = (r_state == ST_DATA) && w_g_val && m_rdy;

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_rr_nxt    = r_rr;
        w_cnt_nxt   = r_cnt;
        w_m_val     = 1'b0;
        w_m_data    = 16'h0000;
        w_s0_rdy    = 1'b0;
        w_s1_rdy    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s0_val || s1_val) begin
                    // r_rr names the source to prefer when both are asking
                    w_src_nxt   = (s0_val && s1_val) ? r_rr : s1_val;
                    w_state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                w_m_val  = 1'b1;
                w_m_data = {HDR_MAGIC, 7'b0000000, r_src};
                if (m_rdy) begin
                    w_cnt_nxt   = 12'd0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_m_val  = w_g_val;
                w_m_data = w_g_data;
                w_s0_rdy = ~r_src & m_rdy;
                w_s1_rdy = r_src & m_rdy;
                if (w_beat) begin
                    if (w_g_last || (r_cnt == LP_CNT_LAST)) begin
                        w_cnt_nxt   = 12'd0;
                        w_rr_nxt    = ~r_src;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 12'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_src   <= 1'b0;
            r_rr    <= 1'b0;
            r_cnt   <= 12'd0;
            r_grant <= 2'b00;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_rr    <= w_rr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_grant <= (w_state_nxt == ST_IDLE) ? 2'b00 : (w_src_nxt ? 2'b10 : 2'b01);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Gating with rst keeps a beat from being consumed on the reset edge itself.
    assign m_val  = w_m_val & ~rst;
    assign m_data = w_m_data;
    assign s0_rdy = w_s0_rdy & ~rst;
    assign s1_rdy = w_s1_rdy & ~rst;
    assign grant  = r_grant;
    assign busy   = r_busy;

endmodule

// File: tb/tb_ft245_tx_arbiter.sv
// Bench for ft245_tx_arbiter: queue-driven sources, output stream checked against a packet-level model.
module tb_ft245_tx_arbiter;

    localparam int         MB  = 4;
    localparam logic [7:0] HDR = 8'hA5;

    logic        clk;
    logic        rst;
    logic        s0_val, s0_rdy, s0_last;
    logic [15:0] s0_data;
    logic        s1_val, s1_rdy, s1_last;
    logic [15:0] s1_data;
    logic        m_val, m_rdy;
    logic [15:0] m_data;
    logic [1:0]  grant;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [16:0] q0[$], q1[$];
    logic [16:0] m0[$], m1[$];
    logic [15:0] out_q[$];
    logic [15:0] exp_q[$];
    bit          model_rr;

    bit          fire0, fire1;
    int          acc0, acc1;
    int          gap0, gap_at0, gap_len, gap_cycles, gap_viol;
    int          rdy_mode;
    bit          hold_pend;
    logic [15:0] hold_dat;
    int          hold_viol, rdy_viol;

    ft245_tx_arbiter #(.HDR_MAGIC(HDR), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .s0_val(s0_val), .s0_rdy(s0_rdy), .s0_data(s0_data), .s0_last(s0_last),
        .s1_val(s1_val), .s1_rdy(s1_rdy), .s1_data(s1_data), .s1_last(s1_last),
        .m_val(m_val), .m_rdy(m_rdy), .m_data(m_data), .grant(grant), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Source/sink driver: samples handshakes mid-cycle, updates drives just after the edge.
    initial begin
        s0_val = 0; s0_data = 0; s0_last = 0;
        s1_val = 0; s1_data = 0; s1_last = 0;
        m_rdy = 1; rdy_mode = 0; gap0 = 0; gap_at0 = -1; gap_len = 0;
        forever begin
            @(negedge clk);
            fire0 = s0_val && s0_rdy;
            fire1 = s1_val && s1_rdy;
            if (m_val && m_rdy) out_q.push_back(m_data);
            if (hold_pend && (!m_val || m_data !== hold_dat)) hold_viol++;
            hold_pend = m_val && !m_rdy;
            hold_dat  = m_data;
            if ((s0_rdy && !(grant == 2'b01 && m_rdy)) || (s1_rdy && !(grant == 2'b10 && m_rdy)))
                rdy_viol++;
            if (gap0 > 0) begin
                gap_cycles++;
                if (m_val || grant !== 2'b01 || s1_rdy) gap_viol++;
            end
            @(posedge clk);
            #1;
            if (fire0 && q0.size() > 0) begin void'(q0.pop_front()); acc0++; end
            if (fire1 && q1.size() > 0) begin void'(q1.pop_front()); acc1++; end
            if (gap0 > 0) gap0--;
            if (fire0 && acc0 == gap_at0) gap0 = gap_len;
            if (q0.size() > 0 && gap0 == 0) begin
                s0_val = 1; {s0_last, s0_data} = q0[0];
            end else begin
                s0_val = 0; s0_last = 0; s0_data = 16'h0;
            end
            if (q1.size() > 0) begin
                s1_val = 1; {s1_last, s1_data} = q1[0];
            end else begin
                s1_val = 0; s1_last = 0; s1_data = 16'h0;
            end
            case (rdy_mode)
                1:       m_rdy = ~m_rdy;
                2:       m_rdy = ($urandom_range(3) != 0);
                default: m_rdy = 1'b1;
            endcase
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic load_pkt(input int src, input int len);
        for (int i = 0; i < len; i++) begin
            logic [16:0] w;
            w = {(i == len - 1), 16'($urandom)};
            if (src == 0) begin q0.push_back(w); m0.push_back(w); end
            else          begin q1.push_back(w); m1.push_back(w); end
        end
    endtask

    // Packet-level model: a source requests while it has beats queued; ties go to model_rr.
    task automatic build_expected();
        exp_q = {};
        while (m0.size() > 0 || m1.size() > 0) begin
            bit          pick;
            int          n;
            logic [16:0] w;
            pick = (m0.size() > 0 && m1.size() > 0) ? model_rr : (m1.size() > 0);
            exp_q.push_back({HDR, 7'b0000000, pick});
            n = 0;
            forever begin
                w = pick ? m1.pop_front() : m0.pop_front();
                exp_q.push_back(w[15:0]);
                n++;
                if (w[16] || n == MB) break;
            end
            model_rr = ~pick;
        end
    endtask

    task automatic apply_reset();
        rst = 1;
        q0 = {}; q1 = {}; m0 = {}; m1 = {};
        step();
        step();
        rst = 0;
        out_q = {}; exp_q = {};
        model_rr = 0; acc0 = 0; acc1 = 0;
        gap0 = 0; gap_at0 = -1; gap_cycles = 0; gap_viol = 0;
        hold_viol = 0; rdy_viol = 0; rdy_mode = 0;
        step();
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k;
        k = 0;
        while ((q0.size() > 0 || q1.size() > 0 || busy) && k < budget) begin
            step();
            k++;
        end
        step();
        checks++;
        if (k >= budget) begin
            failures++;
            $display("FAIL %s_timeout q0=%0d q1=%0d busy=%0d required drained", name, q0.size(), q1.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) step();
        rst = 0;
        step();
        checks += 5;
        if (m_val  !== 1'b0)  begin failures++; $display("FAIL reset_m_val got=%b exp=0", m_val); end
        if (s0_rdy !== 1'b0)  begin failures++; $display("FAIL reset_s0_rdy got=%b exp=0", s0_rdy); end
        if (s1_rdy !== 1'b0)  begin failures++; $display("FAIL reset_s1_rdy got=%b exp=0", s1_rdy); end
        if (grant  !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
        if (busy   !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_packet();
        logic [15:0] d[3];
        bit          e_val[6]  = '{0, 1, 1, 1, 1, 0};
        logic [1:0]  e_gnt[6]  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        bit          e_rdy0[6] = '{0, 0, 1, 1, 1, 0};
        logic [15:0] e_dat[6];
        apply_reset();
        load_pkt(0, 3);
        for (int i = 0; i < 3; i++) d[i] = q0[i][15:0];
        e_dat = '{16'h0, 16'hA500, d[0], d[1], d[2], 16'h0};
        for (int c = 0; c < 6; c++) begin
            step();
            checks += 4;
            if (m_val !== e_val[c]) begin failures++; $display("FAIL single_m_val c=%0d got=%b exp=%b", c, m_val, e_val[c]); end
            if (grant !== e_gnt[c]) begin failures++; $display("FAIL single_grant c=%0d got=%b exp=%b", c, grant, e_gnt[c]); end
            if (busy !== (e_gnt[c] != 2'b00)) begin failures++; $display("FAIL single_busy c=%0d got=%b", c, busy); end
            if (s0_rdy !== e_rdy0[c]) begin failures++; $display("FAIL single_s0_rdy c=%0d got=%b exp=%b", c, s0_rdy, e_rdy0[c]); end
            if (e_val[c]) begin
                checks++;
                if (m_data !== e_dat[c]) begin failures++; $display("FAIL single_m_data c=%0d got=%h exp=%h", c, m_data, e_dat[c]); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] hdrs[4] = '{16'hA500, 16'hA501, 16'hA500, 16'hA501};
        apply_reset();
        load_pkt(0, 2); load_pkt(0, 2);
        load_pkt(1, 2); load_pkt(1, 2);
        build_expected();
        wait_drain(200, "rr");
        checks++;
        if (out_q.size() != exp_q.size()) begin failures++; $display("FAIL rr_len got=%0d exp=%0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin failures++; $display("FAIL rr_word i=%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
        end
        for (int g = 0; g < 4 && 3 * g < out_q.size(); g++) begin
            checks++;
            if (out_q[3*g] !== hdrs[g]) begin failures++; $display("FAIL rr_hdr g=%0d got=%h exp=%h", g, out_q[3*g], hdrs[g]); end
        end
        checks++;
        if (rdy_viol != 0) begin failures++; $display("FAIL rr_rdy_viol got=%0d exp=0", rdy_viol); end
    endtask

    task automatic test_burst_split();
        int hpos[3] = '{0, 5, 10};
        apply_reset();
        load_pkt(1, 10);
        build_expected();
        wait_drain(200, "split");
        checks++;
        if (out_q.size() != 13) begin failures++; $display("FAIL split_len got=%0d exp=13", out_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin failures++; $display("FAIL split_word i=%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
        end
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (hpos[g] >= out_q.size() || out_q[hpos[g]] !== 16'hA501) begin
                failures++; $display("FAIL split_hdr pos=%0d exp=a501", hpos[g]);
            end
        end
    endtask

    task automatic test_rdy_toggle();
        apply_reset();
        rdy_mode = 1;
        for (int p = 0; p < 3; p++) load_pkt(1, 1 + $urandom_range(6));
        build_expected();
        wait_drain(400, "toggle");
        rdy_mode = 0;
        checks++;
        if (out_q.size() != exp_q.size()) begin failures++; $display("FAIL toggle_len got=%0d exp=%0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin failures++; $display("FAIL toggle_word i=%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
        end
        checks += 2;
        if (hold_viol != 0) begin failures++; $display("FAIL toggle_hold got=%0d exp=0", hold_viol); end
        if (rdy_viol != 0)  begin failures++; $display("FAIL toggle_rdy got=%0d exp=0", rdy_viol); end
    endtask

    task automatic test_val_gap();
        apply_reset();
        gap_at0 = 1;
        gap_len = 5;
        load_pkt(0, 3);
        load_pkt(1, 2);
        build_expected();
        wait_drain(200, "gap");
        gap_at0 = -1;
        checks += 3;
        if (gap_cycles != 5) begin failures++; $display("FAIL gap_cycles got=%0d exp=5", gap_cycles); end
        if (gap_viol != 0)   begin failures++; $display("FAIL gap_hold got=%0d exp=0", gap_viol); end
        if (out_q.size() != exp_q.size()) begin failures++; $display("FAIL gap_len got=%0d exp=%0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin failures++; $display("FAIL gap_word i=%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int k;
        apply_reset();
        load_pkt(0, 1);
        build_expected();
        wait_drain(100, "rstpre");
        out_q = {};
        acc0 = 0;
        load_pkt(0, 6);
        m0 = {};
        k = 0;
        while (acc0 < 2 && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        checks++;
        if (acc0 != 2) begin failures++; $display("FAIL rstmid_reach got=%0d exp=2", acc0); end
        rst = 1;
        q0 = {};
        @(posedge clk);
        #2;
        rst = 0;
        @(negedge clk);
        #2;
        checks += 6;
        if (m_val  !== 1'b0)  begin failures++; $display("FAIL rstmid_m_val got=%b exp=0", m_val); end
        if (grant  !== 2'b00) begin failures++; $display("FAIL rstmid_grant got=%b exp=00", grant); end
        if (busy   !== 1'b0)  begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        if (s0_rdy !== 1'b0)  begin failures++; $display("FAIL rstmid_s0_rdy got=%b exp=0", s0_rdy); end
        if (s1_rdy !== 1'b0)  begin failures++; $display("FAIL rstmid_s1_rdy got=%b exp=0", s1_rdy); end
        if (out_q.size() != 3) begin failures++; $display("FAIL rstmid_beats got=%0d exp=3", out_q.size()); end
        out_q = {};
        model_rr = 0;
        load_pkt(0, 2);
        load_pkt(1, 2);
        build_expected();
        wait_drain(100, "rstpost");
        checks++;
        if (out_q.size() == 0 || out_q[0] !== 16'hA500) begin
            failures++; $display("FAIL rstmid_pref got=%h exp=a500", (out_q.size() > 0) ? out_q[0] : 16'hxxxx);
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin failures++; $display("FAIL rstmid_word i=%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        rdy_mode = 2;
        for (int p = 0; p < 6; p++) begin
            load_pkt(0, 1 + $urandom_range(8));
            load_pkt(1, 1 + $urandom_range(8));
        end
        build_expected();
        wait_drain(3000, "rand");
        rdy_mode = 0;
        checks++;
        if (out_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_len got=%0d exp=%0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_word i=%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
        end
        checks += 2;
        if (hold_viol != 0) begin failures++; $display("FAIL rand_hold got=%0d exp=0", hold_viol); end
        if (rdy_viol != 0)  begin failures++; $display("FAIL rand_rdy got=%0d exp=0", rdy_viol); end
    endtask

    initial begin
        rst = 1;
        hold_pend = 0; hold_viol = 0; rdy_viol = 0;
        acc0 = 0; acc1 = 0; gap_cycles = 0; gap_viol = 0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_burst_split();
        test_rdy_toggle();
        test_val_gap();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
